pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter AES_TIMEOUT, default 255, meaning max cycles spent in WAIT_AES before forced exit (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pc_cur  input  32  current PC register value.
REQ-005 SHALL have port jump  input  1  jump request this cycle.
REQ-006 SHALL have port jump_target  input  32  jump destination.
REQ-007 SHALL have port branch_taken  input  1  resolved taken branch this cycle.
REQ-008 SHALL have port branch_target  input  32  branch destination.
REQ-009 SHALL have port load_use  input  1  load-use hazard, single-cycle stall request.
REQ-010 SHALL have port aes_start  input  1  AES coprocessor instruction issued.
REQ-011 SHALL have port aes_done  input  1  AES coprocessor completion pulse.
REQ-012 SHALL have port pc_next  output  32  value for PC register input.
REQ-013 SHALL have port pc_stall  output  1  PC register hold enable.
REQ-014 SHALL have port flush  output  1  squash IF/ID contents.
REQ-015 SHALL have port aes_busy  output  1  registered, high while in WAIT_AES.
REQ-016 SHALL have port aes_timeout  output  1  sticky flag, set on watchdog expiry.

Function
REQ-017 SHALL implement a 3-state FSM: RUN=0, WAIT_AES=1, FLUSH=2; encoding 3 unused, recovers to RUN next cycle.
REQ-018 pc_next, pc_stall, flush SHALL be combinational from state and inputs (same-cycle response); aes_busy, aes_timeout, state, watchdog counter SHALL be registered.
REQ-019 Sequential PC SHALL be pc_cur+4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-020 Redirect targets SHALL be output with bits [1:0] forced to 00.
REQ-021 RUN priority, highest first: jump, branch_taken, aes_start, load_use, sequential.
REQ-022 RUN+jump: pc_next=jump_target, pc_stall=0, flush=1, next state FLUSH.
REQ-023 RUN+branch_taken (no jump): pc_next=branch_target, pc_stall=0, flush=1, next state FLUSH.
REQ-024 RUN+aes_start (no redirect): pc_stall=1, pc_next=pc_cur, next state WAIT_AES, counter cleared to 0.
REQ-025 RUN+load_use only: pc_stall=1, pc_next=pc_cur, flush=0, stay RUN; consecutive load_use cycles each stall one cycle.
REQ-026 WAIT_AES: pc_stall=1, pc_next=pc_cur, flush=0; counter increments each cycle; all other requests ignored.
REQ-027 WAIT_AES+aes_done: next state RUN, pc_stall still 1 this cycle; aes_done outside WAIT_AES ignored.
REQ-028 WAIT_AES, counter==AES_TIMEOUT-1 without aes_done: set aes_timeout, next state RUN; aes_done same cycle takes precedence (no flag).
REQ-029 FLUSH: flush=1, pc_stall=0, pc_next=pc_cur+4, jump/branch/aes_start/load_use ignored (squashed slot), next state RUN.
REQ-030 aes_timeout SHALL stay set until reset.

Reset
REQ-031 rst low SHALL immediately force state=RUN, counter=0, aes_busy=0, aes_timeout=0, independent of clk.
REQ-032 With all request inputs low during/after reset: pc_next=pc_cur+4, pc_stall=0, flush=0.
REQ-033 Reset asserted in WAIT_AES or FLUSH SHALL abandon the operation; first cycle after release is RUN.

Verification
REQ-034 pc_cur=0x100, no requests -> pc_next=0x104, pc_stall=0, flush=0; pc_cur=0xFFFFFFFC -> pc_next=0x0.
REQ-035 RUN, jump=1 jump_target=0x2003, branch_taken=1 branch_target=0x400 -> pc_next=0x2000, flush=1; next cycle FLUSH, flush=1, branch ignored; then RUN.
REQ-036 RUN, aes_start=1 -> pc_stall=1; aes_busy=1 next cycle; aes_done after 5 cycles -> aes_busy=0 next edge, pc_stall=0, aes_timeout=0.
REQ-037 AES_TIMEOUT=4, aes_start, no aes_done -> 4 WAIT_AES cycles, then RUN with aes_timeout=1, stays 1 until rst.
REQ-038 load_use high 3 cycles in RUN -> pc_stall=1, pc_next=pc_cur each cycle, flush=0, state stays RUN.
REQ-039 rst pulsed low mid-WAIT_AES (no clk edge) -> aes_busy=0 immediately; after release, sequential pc_next=pc_cur+4.

Source files
------------

// File: rtl/pc_ctrl.sv
// PC sequencing controller: selects the next PC and raises stall/flush for
// jumps, taken branches, load-use hazards and AES coprocessor waits.
module pc_ctrl #(
  parameter int unsigned AES_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        load_use,
  input  logic        aes_start,
  input  logic        aes_done,
  output logic [31:0] pc_next,
  output logic        pc_stall,
  output logic        flush,
  output logic        aes_busy,
  output logic        aes_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_AES = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(AES_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        tmo_q, tmo_d;
  logic [31:0] seq_pc;

  assign seq_pc      = pc_cur + 32'd4;
  assign aes_busy    = busy_q;
  assign aes_timeout = tmo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    pc_next  = seq_pc;
    pc_stall = 1'b0;
    flush    = 1'b0;
    case (state_q)
      RUN: begin
        if (jump) begin
          pc_next = {jump_target[31:2], 2'b00};
          flush   = 1'b1;
          state_d = FLUSH;
        end else if (branch_taken) begin
          pc_next = {branch_target[31:2], 2'b00};
          flush   = 1'b1;
          state_d = FLUSH;
        end else if (aes_start) begin
          pc_next  = pc_cur;
          pc_stall = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT_AES;
        end else if (load_use) begin
          pc_next  = pc_cur;
          pc_stall = 1'b1;
        end
      end
      WAIT_AES: begin
        pc_next  = pc_cur;
        pc_stall = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        // A completion in the expiry cycle wins, so the flag is not raised.
        if (aes_done) begin
          state_d = RUN;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    busy_d = (state_d == WAIT_AES);
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a default instance and one with AES_TIMEOUT=4
// share all inputs; expected {pc_next,pc_stall,flush,aes_busy,aes_timeout}.
module tb_pc_ctrl;

  logic        clk, rst;
  logic [31:0] pc_cur, jump_target, branch_target;
  logic        jump, branch_taken, load_use, aes_start, aes_done;
  logic [31:0] pn_d, pn_t;
  logic        st_d, st_t, fl_d, fl_t, bz_d, bz_t, tm_d, tm_t;

  pc_ctrl dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .load_use(load_use),
    .aes_start(aes_start), .aes_done(aes_done), .pc_next(pn_d), .pc_stall(st_d),
    .flush(fl_d), .aes_busy(bz_d), .aes_timeout(tm_d)
  );

  pc_ctrl #(.AES_TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .load_use(load_use),
    .aes_start(aes_start), .aes_done(aes_done), .pc_next(pn_t), .pc_stall(st_t),
    .flush(fl_t), .aes_busy(bz_t), .aes_timeout(tm_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [35:0] obs_d, obs_t;
  assign obs_d = {pn_d, st_d, fl_d, bz_d, tm_d};
  assign obs_t = {pn_t, st_t, fl_t, bz_t, tm_t};

  typedef struct packed {
    logic        j;
    logic [31:0] jt;
    logic        b;
    logic [31:0] bt;
    logic        lu;
    logic        sa;
    logic        dn;
    logic [31:0] pc;
    logic [35:0] ev;
  } stim_t;

  stim_t       stq[$];
  logic [35:0] sbq[$];
  int          passed = 0;
  int          total  = 0;

  function automatic logic [35:0] E(logic [31:0] pc, logic st, logic fl, logic bz, logic tm);
    return {pc, st, fl, bz, tm};
  endfunction

  function automatic void add(logic j, logic [31:0] jt, logic b, logic [31:0] bt, logic lu,
                              logic sa, logic dn, logic [31:0] pc, logic [35:0] ev);
    stim_t s;
    s.j = j; s.jt = jt; s.b = b; s.bt = bt; s.lu = lu;
    s.sa = sa; s.dn = dn; s.pc = pc; s.ev = ev;
    stq.push_back(s);
  endfunction

  task automatic apply(input stim_t s);
    jump = s.j; jump_target = s.jt; branch_taken = s.b; branch_target = s.bt;
    load_use = s.lu; aes_start = s.sa; aes_done = s.dn; pc_cur = s.pc;
    sbq.push_back(s.ev);
  endtask

  task automatic idle_inputs(input logic [31:0] pc);
    jump = 0; jump_target = '0; branch_taken = 0; branch_target = '0;
    load_use = 0; aes_start = 0; aes_done = 0; pc_cur = pc;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [35:0] ev;
    rst = 1'b0;
    idle_inputs(32'h100);
    #2;
    ev = E(32'h104, 0, 0, 0, 0);
    total++;
    if (obs_d !== ev) $display("FAIL reset_dflt got %h exp %h", obs_d, ev); else passed++;
    total++;
    if (obs_t !== ev) $display("FAIL reset_tmo4 got %h exp %h", obs_t, ev); else passed++;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_seq();
    stim_t s; logic [35:0] ev; int n = 0;
    add(0, 0, 0, 0, 0, 0, 0, 32'h100,      E(32'h104, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, E(32'h0,   0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'h8,        E(32'hC,   0, 0, 0, 0));
    while (stq.size() > 0) begin
      s = stq.pop_front(); apply(s);
      @(negedge clk); ev = sbq.pop_front(); total++;
      if (obs_d !== ev) $display("FAIL seq[%0d] got %h exp %h", n, obs_d, ev); else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    stim_t s; logic [35:0] ev; int n = 0;
    add(1, 32'h2003, 1, 32'h400, 0, 0, 0, 32'h1000, E(32'h2000, 0, 1, 0, 0));
    add(0, 0, 1, 32'h400, 1, 1, 0, 32'h2000, E(32'h2004, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'h2004, E(32'h2008, 0, 0, 0, 0));
    add(0, 0, 1, 32'h403, 1, 1, 0, 32'h2008, E(32'h400, 0, 1, 0, 0));
    add(1, 32'h9000, 0, 0, 0, 0, 0, 32'h400, E(32'h404, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'h404, E(32'h408, 0, 0, 0, 0));
    while (stq.size() > 0) begin
      s = stq.pop_front(); apply(s);
      @(negedge clk); ev = sbq.pop_front(); total++;
      if (obs_d !== ev) $display("FAIL redirect[%0d] got %h exp %h", n, obs_d, ev); else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s; logic [35:0] ev; int n = 0;
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 0, 32'h700, E(32'h700, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'h700, E(32'h704, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 1, 0, 32'h704, E(32'h704, 1, 0, 0, 0));
    add(0, 0, 0, 0, 1, 0, 1, 32'h704, E(32'h704, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'h704, E(32'h708, 0, 0, 0, 0));
    while (stq.size() > 0) begin
      s = stq.pop_front(); apply(s);
      @(negedge clk); ev = sbq.pop_front(); total++;
      if (obs_d !== ev) $display("FAIL load_use[%0d] got %h exp %h", n, obs_d, ev); else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_aes();
    stim_t s; logic [35:0] ev; int n = 0;
    add(0, 0, 0, 0, 0, 1, 0, 32'h300, E(32'h300, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) add(1, 32'h5000, 1, 32'h600, 1, 1, 0, 32'h300, E(32'h300, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 1, 32'h300, E(32'h300, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 1, 32'h300, E(32'h304, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'h304, E(32'h308, 0, 0, 0, 0));
    while (stq.size() > 0) begin
      s = stq.pop_front(); apply(s);
      @(negedge clk); ev = sbq.pop_front(); total++;
      if (obs_d !== ev) $display("FAIL aes[%0d] got %h exp %h", n, obs_d, ev); else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t s; logic [35:0] ev; int n = 0;
    pulse_reset();
    add(0, 0, 0, 0, 0, 1, 0, 32'h500, E(32'h500, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 32'h500, E(32'h500, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'h500, E(32'h504, 0, 0, 0, 1));
    add(0, 0, 0, 0, 0, 0, 1, 32'h504, E(32'h508, 0, 0, 0, 1));
    add(1, 32'h600, 0, 0, 0, 0, 0, 32'h508, E(32'h600, 0, 1, 0, 1));
    add(0, 0, 0, 0, 0, 0, 0, 32'h600, E(32'h604, 0, 1, 0, 1));
    while (stq.size() > 0) begin
      s = stq.pop_front(); apply(s);
      @(negedge clk); ev = sbq.pop_front(); total++;
      if (obs_t !== ev) $display("FAIL timeout[%0d] got %h exp %h", n, obs_t, ev); else passed++;
      n++; @(posedge clk); #1;
    end
    idle_inputs(32'h604);
    rst = 1'b0; #1;
    ev = E(32'h608, 0, 0, 0, 0); total++;
    if (obs_t !== ev) $display("FAIL timeout_clear got %h exp %h", obs_t, ev); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    add(0, 0, 0, 0, 0, 1, 0, 32'h500, E(32'h500, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 32'h500, E(32'h500, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 1, 32'h500, E(32'h500, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'h500, E(32'h504, 0, 0, 0, 0));
    while (stq.size() > 0) begin
      s = stq.pop_front(); apply(s);
      @(negedge clk); ev = sbq.pop_front(); total++;
      if (obs_t !== ev) $display("FAIL done_at_expiry[%0d] got %h exp %h", n, obs_t, ev); else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_op();
    stim_t s; logic [35:0] ev; int n = 0;
    pulse_reset();
    add(0, 0, 0, 0, 0, 1, 0, 32'h800, E(32'h800, 1, 0, 0, 0));
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 0, 32'h800, E(32'h800, 1, 0, 1, 0));
    while (stq.size() > 0) begin
      s = stq.pop_front(); apply(s);
      @(negedge clk); ev = sbq.pop_front(); total++;
      if (obs_d !== ev) $display("FAIL mid_wait[%0d] got %h exp %h", n, obs_d, ev); else passed++;
      n++; @(posedge clk); #1;
    end
    #2 rst = 1'b0; #1;
    ev = E(32'h804, 0, 0, 0, 0); total++;
    if (obs_d !== ev) $display("FAIL rst_in_wait got %h exp %h", obs_d, ev); else passed++;
    rst = 1'b1; #1; total++;
    if (obs_d !== ev) $display("FAIL rst_release got %h exp %h", obs_d, ev); else passed++;
    @(posedge clk); #1;
    add(0, 0, 0, 0, 0, 0, 0, 32'h804, E(32'h808, 0, 0, 0, 0));
    add(1, 32'h900, 0, 0, 0, 0, 0, 32'h808, E(32'h900, 0, 1, 0, 0));
    while (stq.size() > 0) begin
      s = stq.pop_front(); apply(s);
      @(negedge clk); ev = sbq.pop_front(); total++;
      if (obs_d !== ev) $display("FAIL post_rst[%0d] got %h exp %h", n, obs_d, ev); else passed++;
      n++; @(posedge clk); #1;
    end
    idle_inputs(32'h900);
    #1; ev = E(32'h904, 0, 1, 0, 0); total++;
    if (obs_d !== ev) $display("FAIL flush_state got %h exp %h", obs_d, ev); else passed++;
    rst = 1'b0; #1;
    ev = E(32'h904, 0, 0, 0, 0); total++;
    if (obs_d !== ev) $display("FAIL rst_in_flush got %h exp %h", obs_d, ev); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    stim_t s; logic [35:0] ev; int n = 0;
    add(0, 0, 1, 32'hB00, 0, 0, 0, 32'hA00, E(32'hB00, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'hB00, E(32'hB04, 0, 1, 0, 0));
    add(1, 32'hC00, 0, 0, 0, 0, 0, 32'hB04, E(32'hC00, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'hC00, E(32'hC04, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 1, 0, 32'hC04, E(32'hC04, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 1, 32'hC04, E(32'hC04, 1, 0, 1, 0));
    add(0, 0, 0, 0, 1, 0, 0, 32'hC04, E(32'hC04, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 32'hC04, E(32'hC08, 0, 0, 0, 0));
    while (stq.size() > 0) begin
      s = stq.pop_front(); apply(s);
      @(negedge clk); ev = sbq.pop_front(); total++;
      if (obs_d !== ev) $display("FAIL back_to_back[%0d] got %h exp %h", n, obs_d, ev); else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_redirect();
    test_load_use();
    test_aes();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
